// File: rtl/des_key_sched_seq_pkg.sv
// des_pkg: shared constants, permutation tables and helpers for the DES key schedule
package des_pkg;
  localparam int KEY_W = 56;
  localparam int RK_W  = 48;
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [1:0] SHIFT_SCHED [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  // DES bit 1 is the MSB, so a DES left shift moves bits toward the MSB
  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] amount);
    return amount == 2'd2 ? {v[25:0], v[27:26]} : amount == 2'd1 ? {v[26:0], v[27]} : v;
  endfunction
  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] amount);
    return amount == 2'd2 ? {v[1:0], v[27:2]} : amount == 2'd1 ? {v[0], v[27:1]} : v;
  endfunction
  // Result bit 55 is PC-1 output bit 1; parity bits are never selected
  function automatic logic [KEY_W-1:0] pc1(input logic [63:0] key);
    logic [KEY_W-1:0] cd;
    for (int i = 0; i < KEY_W; i++) cd[6'(KEY_W-1-i)] = key[6'(64-PC1[i])];
    return cd;
  endfunction
endpackage

// File: rtl/des_rot_stage.sv
// des_rot_stage: one schedule step, rotating C/D for emission index round_i and forming its round key
module des_rot_stage import des_pkg::*; (
  input  logic [27:0]     c_i,
  input  logic [27:0]     d_i,
  input  logic            decrypt_i,
  input  logic [3:0]      round_i,
  output logic [27:0]     c_o,
  output logic [27:0]     d_o,
  output logic [RK_W-1:0] rk_o
);
  logic [3:0] back;
  logic [1:0] amt;
  assign back = 4'd0 - round_i;
  // decrypt walks the schedule backwards; the first emitted key (K16) needs no rotation
  assign amt = decrypt_i ? (round_i == 4'd0 ? 2'd0 : SHIFT_SCHED[back]) : SHIFT_SCHED[round_i];
  assign c_o = decrypt_i ? rotr28(c_i, amt) : rotl28(c_i, amt);
  assign d_o = decrypt_i ? rotr28(d_i, amt) : rotl28(d_i, amt);
  p_box_56_48 u_pc2 (.din({c_o, d_o}), .dout(rk_o));
endmodule

// File: rtl/p_box_56_48.sv
// p_box_56_48: PC-2 compression permutation of the 56-bit C/D state into a round key
module p_box_56_48 import des_pkg::*; (
  input  logic [KEY_W-1:0] din,
  output logic [RK_W-1:0]  dout
);
  logic unused_din;
  assign unused_din = ^din;
  for (genvar i = 0; i < RK_W; i++) begin : g_bit
    assign dout[RK_W-1-i] = din[KEY_W-PC2[i]];
  end
endmodule

// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq: sequential DES key schedule streaming 16 round keys per loaded key
module des_key_sched_seq import des_pkg::*; #(
  parameter int KEYS_PER_BEAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [63:0]                   key_in,
  input  logic                          key_decrypt,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic                          flush,
  output logic [RK_W*KEYS_PER_BEAT-1:0] round_key_out,
  output logic [3:0]                    round_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);
  localparam int BEAT_W = 16 / KEYS_PER_BEAT;
  localparam int SH = $clog2(KEYS_PER_BEAT);
  state_e state_q;
  logic [27:0] c_q, d_q;
  logic dec_q;
  logic [3:0] beat_q;
  logic idle, mode, accept, adv, fin;
  logic [3:0] beat_d, base_j;
  logic [KEY_W-1:0] cd0;
  logic [27:0] cc [KEYS_PER_BEAT+1];
  logic [27:0] dd [KEYS_PER_BEAT+1];
  logic [RK_W*KEYS_PER_BEAT-1:0] rk_d;
  logic unused_key;
  assign unused_key = ^key_in;
  assign idle = state_q == IDLE;
  assign key_ready = idle;
  assign cd0 = pc1(key_in);
  assign mode = idle ? key_decrypt : dec_q;
  assign accept = idle & key_valid;
  assign adv = !idle & out_valid & out_ready;
  assign fin = beat_q == 4'(BEAT_W - 1);
  assign beat_d = idle ? 4'd0 : beat_q + 4'd1;
  assign base_j = beat_d << SH;
  assign cc[0] = idle ? cd0[55:28] : c_q;
  assign dd[0] = idle ? cd0[27:0] : d_q;
  for (genvar i = 0; i < KEYS_PER_BEAT; i++) begin : g_lane
    des_rot_stage u_stage (
      .c_i      (cc[i]),
      .d_i      (dd[i]),
      .decrypt_i(mode),
      .round_i  (base_j + 4'(i)),
      .c_o      (cc[i+1]),
      .d_o      (dd[i+1]),
      .rk_o     (rk_d[i*RK_W +: RK_W])
    );
  end
  // control FSM: load a key, then register one beat ahead so outputs stay put while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      c_q           <= '0;
      d_q           <= '0;
      dec_q         <= 1'b0;
      beat_q        <= '0;
      round_key_out <= '0;
      round_idx     <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      beat_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept | (adv & !fin)) begin
      state_q       <= RUN;
      c_q           <= cc[KEYS_PER_BEAT];
      d_q           <= dd[KEYS_PER_BEAT];
      dec_q         <= mode;
      beat_q        <= beat_d;
      round_key_out <= rk_d;
      round_idx     <= mode ? 4'd15 - base_j : base_j;
      out_valid     <= 1'b1;
      out_last      <= beat_d == 4'(BEAT_W - 1);
    end else if (adv) begin
      state_q   <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      beat_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb_des_key_sched_seq: randomized self-checking bench for the DES key schedule engine
module tb_des_key_sched_seq;
  localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;
  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic key_decrypt = 1'b0, key_valid1 = 1'b0, key_valid4 = 1'b0, flush = 1'b0;
  logic out_ready1 = 1'b0, out_ready4 = 1'b0;
  logic key_ready1, ov1, last1, key_ready4, ov4, last4;
  logic [47:0] rk1;
  logic [191:0] rk4;
  logic [3:0] idx1, idx4;
  logic [47:0] exp_k [16];
  logic [47:0] got [16];
  logic [191:0] g4;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  des_key_sched_seq #(.KEYS_PER_BEAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_decrypt(key_decrypt), .key_valid(key_valid1),
    .key_ready(key_ready1), .flush(flush), .round_key_out(rk1), .round_idx(idx1),
    .out_valid(ov1), .out_ready(out_ready1), .out_last(last1)
  );
  des_key_sched_seq #(.KEYS_PER_BEAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_decrypt(key_decrypt), .key_valid(key_valid4),
    .key_ready(key_ready4), .flush(flush), .round_key_out(rk4), .round_idx(idx4),
    .out_valid(ov4), .out_ready(out_ready4), .out_last(last4)
  );

  // K(r+1) straight from the standard: PC-1, cumulative left rotation, PC-2
  function automatic logic [47:0] ref_key(input logic [63:0] key, input int r);
    logic [27:0] c, d;
    logic [55:0] cc, dd, cd;
    logic [47:0] k;
    int tot;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1_T[i]];
      d[27-i] = key[64-PC1_T[28+i]];
    end
    tot = 0;
    for (int i = 0; i <= r; i++) tot += (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
    tot = tot % 28;
    cc = {c, c} << tot;
    dd = {d, d} << tot;
    cd = {cc[55:28], dd[55:28]};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
    return k;
  endfunction

  task automatic run_sched(input logic [63:0] k, input logic dec, input int pct, input logic poke);
    int j, cyc, idx;
    logic acc;
    for (int r = 0; r < 16; r++) exp_k[r] = ref_key(k, r);
    @(negedge clk);
    n_cmp++;
    if (key_ready1 !== 1'b1) begin n_err++; $display("FAIL ready_before_key: got %b want 1", key_ready1); end
    key_in = k; key_decrypt = dec; key_valid1 = 1'b1; out_ready1 = 1'b0;
    @(negedge clk);
    key_valid1 = 1'b0;
    n_cmp++;
    if (ov1 !== 1'b1 || key_ready1 !== 1'b0) begin
      n_err++; $display("FAIL first_beat_latency: out_valid=%b key_ready=%b want 1/0", ov1, key_ready1);
    end
    j = 0; cyc = 0;
    while (j < 16 && cyc < 500) begin
      idx = dec ? 15 - j : j;
      n_cmp++;
      if (ov1 !== 1'b1 || rk1 !== exp_k[idx] || idx1 !== 4'(idx) || last1 !== (j == 15) || key_ready1 !== 1'b0) begin
        n_err++;
        $display("FAIL beat_%0d: valid=%b key=%h idx=%0d last=%b ready=%b want 1/%h/%0d/%b/0",
                 j, ov1, rk1, idx1, last1, key_ready1, exp_k[idx], idx, j == 15);
        break;
      end
      got[j] = rk1;
      out_ready1 = $urandom_range(99) < pct;
      key_valid1 = poke ? 1'($urandom_range(1)) : 1'b0;
      key_in = {$urandom, $urandom};
      key_decrypt = 1'($urandom_range(1));
      acc = ov1 && out_ready1;
      @(negedge clk);
      j += int'(acc); cyc++;
    end
    key_valid1 = 1'b0; out_ready1 = 1'b0;
    n_cmp++;
    if (j != 16 || ov1 !== 1'b0 || last1 !== 1'b0 || key_ready1 !== 1'b1) begin
      n_err++; $display("FAIL schedule_end: keys=%0d valid=%b last=%b ready=%b want 16/0/0/1", j, ov1, last1, key_ready1);
    end
  endtask

  task automatic run4(input logic [63:0] k, input logic dec, input int pct);
    int b, cyc, ix;
    logic acc;
    logic bad;
    for (int r = 0; r < 16; r++) exp_k[r] = ref_key(k, r);
    @(negedge clk);
    key_in = k; key_decrypt = dec; key_valid4 = 1'b1; out_ready4 = 1'b0;
    @(negedge clk);
    key_valid4 = 1'b0;
    b = 0; cyc = 0;
    while (b < 4 && cyc < 200) begin
      bad = ov4 !== 1'b1 || idx4 !== 4'(dec ? 15 - 4*b : 4*b) || last4 !== (b == 3);
      for (int l = 0; l < 4; l++) begin
        ix = dec ? 15 - (4*b + l) : 4*b + l;
        if (rk4[l*48 +: 48] !== exp_k[ix]) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL kpb4_beat_%0d: valid=%b idx=%0d last=%b lanes=%h want idx %0d, lane0 %h",
                 b, ov4, idx4, last4, rk4, dec ? 15 - 4*b : 4*b, exp_k[dec ? 15 - 4*b : 4*b]);
        break;
      end
      if (b == 0) g4 = rk4;
      out_ready4 = $urandom_range(99) < pct;
      acc = ov4 && out_ready4;
      @(negedge clk);
      b += int'(acc); cyc++;
    end
    out_ready4 = 1'b0;
    n_cmp++;
    if (b != 4 || ov4 !== 1'b0 || key_ready4 !== 1'b1) begin
      n_err++; $display("FAIL kpb4_end: beats=%0d valid=%b ready=%b want 4/0/1", b, ov4, key_ready4);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if (ov1 !== 1'b0 || last1 !== 1'b0 || idx1 !== 4'd0 || rk1 !== 48'd0 || key_ready1 !== 1'b1 ||
        ov4 !== 1'b0 || rk4 !== 192'd0 || key_ready4 !== 1'b1) begin
      n_err++; $display("FAIL reset_state: valid=%b last=%b idx=%0d key=%h ready=%b want 0/0/0/0/1", ov1, last1, idx1, rk1, key_ready1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (key_ready1 !== 1'b1 || ov1 !== 1'b0) begin
      n_err++; $display("FAIL after_reset: ready=%b valid=%b want 1/0", key_ready1, ov1);
    end
  endtask

  task automatic test_known_vector;
    run_sched(KNOWN, 1'b0, 100, 1'b0);
    n_cmp++;
    if (got[0] !== 48'h1B02EFFC7072 || got[1] !== 48'h79AED9DBC9E5 || got[15] !== 48'hCB3D8B0E17F5) begin
      n_err++; $display("FAIL known_encrypt: k1=%h k2=%h k16=%h want 1b02effc7072/79aed9dbc9e5/cb3d8b0e17f5", got[0], got[1], got[15]);
    end
    run_sched(KNOWN, 1'b1, 100, 1'b0);
    n_cmp++;
    if (got[0] !== 48'hCB3D8B0E17F5 || got[15] !== 48'h1B02EFFC7072) begin
      n_err++; $display("FAIL known_decrypt: first=%h last=%h want cb3d8b0e17f5/1b02effc7072", got[0], got[15]);
    end
  endtask

  task automatic test_kpb4;
    run4(KNOWN, 1'b0, 100);
    n_cmp++;
    if (g4[47:0] !== 48'h1B02EFFC7072 || g4[95:48] !== 48'h79AED9DBC9E5) begin
      n_err++; $display("FAIL kpb4_known: lane0=%h lane1=%h want 1b02effc7072/79aed9dbc9e5", g4[47:0], g4[95:48]);
    end
    for (int n = 0; n < 6; n++) run4({$urandom, $urandom}, 1'(n), 50);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 100; n++) run_sched({$urandom, $urandom}, 1'($urandom_range(1)), 50, 1'b1);
  endtask

  task automatic test_flush;
    int cyc;
    @(negedge clk);
    key_in = {$urandom, $urandom}; key_decrypt = 1'b0; key_valid1 = 1'b1; out_ready1 = 1'b1;
    @(negedge clk);
    key_valid1 = 1'b0;
    cyc = 0;
    while (!(ov1 === 1'b1 && idx1 === 4'd7) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (ov1 !== 1'b1 || idx1 !== 4'd7) begin
      n_err++; $display("FAIL flush_reach_7: valid=%b idx=%0d want 1/7", ov1, idx1);
    end
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov1 !== 1'b0 || last1 !== 1'b0 || key_ready1 !== 1'b1) begin
      n_err++; $display("FAIL flush_abort: valid=%b last=%b ready=%b want 0/0/1", ov1, last1, key_ready1);
    end
    key_in = {$urandom, $urandom}; key_valid1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov1 !== 1'b0 || key_ready1 !== 1'b1) begin
      n_err++; $display("FAIL flush_drops_key: valid=%b ready=%b want 0/1", ov1, key_ready1);
    end
    flush = 1'b0; key_valid1 = 1'b0; out_ready1 = 1'b0;
    run_sched({$urandom, $urandom}, 1'b0, 100, 1'b0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    key_in = {$urandom, $urandom}; key_decrypt = 1'b1; key_valid1 = 1'b1; out_ready1 = 1'b1;
    @(negedge clk);
    key_valid1 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov1 !== 1'b0 || last1 !== 1'b0 || idx1 !== 4'd0 || rk1 !== 48'd0 || key_ready1 !== 1'b1) begin
      n_err++; $display("FAIL async_reset: valid=%b last=%b idx=%0d key=%h ready=%b want 0/0/0/0/1", ov1, last1, idx1, rk1, key_ready1);
    end
    #4 rst_n = 1'b1;
    out_ready1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ov1 !== 1'b0 || key_ready1 !== 1'b1) begin
      n_err++; $display("FAIL after_async_reset: valid=%b ready=%b want 0/1", ov1, key_ready1);
    end
    run_sched({$urandom, $urandom}, 1'b0, 70, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_known_vector;
    test_kpb4;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
